// File: rtl/ft601_mcfifo_rd_buf.sv
// Receive-side store-and-forward packet buffer for one FT601 channel.
// Bursts are requested only when a full max-size packet fits; packets are released once closed.
module ft601_mcfifo_rd_buf #(
    parameter int CAPACITY        = 8192,
    parameter int MAX_PACKET_SIZE = 1024,
    parameter int PKT_QUEUE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_be,
    input  logic        in_en,
    input  logic        in_end,
    input  logic        in_rx_avail,
    output logic        xfer_req,
    input  logic        xfer_grant,
    output logic        xfer_active,
    output logic        has_packet_space,
    output logic [31:0] out_data,
    output logic [3:0]  out_be,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic [3:0]  out_packet_count,
    output logic        err_overflow
);
    localparam int DEPTH = CAPACITY / 4;
    localparam int AW = $clog2(DEPTH);
    localparam int QW = (PKT_QUEUE_DEPTH > 1) ? $clog2(PKT_QUEUE_DEPTH) : 1;
    localparam logic [15:0] MAX_BYTES   = 16'(MAX_PACKET_SIZE);
    localparam logic [15:0] SPACE_LIMIT = 16'(CAPACITY - MAX_PACKET_SIZE);
    localparam logic [3:0]  QDEPTH      = 4'(PKT_QUEUE_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, ACTIVE, CLOSE} state_t;

    state_t       state_reg;
    logic         xfer_req_reg, xfer_active_reg, has_space_reg, err_reg;
    logic [15:0]  pkt_bytes_reg, data_count_reg, data_count_next;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [13:0]  q_len_reg [PKT_QUEUE_DEPTH];
    logic [QW-1:0] q_wr_reg, q_fetch_reg;
    logic [PKT_QUEUE_DEPTH-1:0] q_sel;
    logic [3:0]   fetch_pending_reg, fetch_pending_next;
    logic [3:0]   pkt_count_reg, pkt_count_next;
    logic [13:0]  fetch_word_reg, q_head_len;
    logic         out_valid_reg, out_last_reg;
    logic [35:0]  mem [DEPTH];
    logic [35:0]  rd_word_reg;
    logic         accept, push, consume, drain_last, fetch, fetch_is_last;

    assign accept        = (state_reg == ACTIVE) && in_en;
    assign push          = (state_reg == CLOSE) && (pkt_bytes_reg != 16'd0);
    assign consume       = out_valid_reg && out_ready;
    assign drain_last    = consume && out_last_reg;
    // Prefetch into the output register only from packets that are already closed.
    assign fetch         = (fetch_pending_reg != 4'd0) && (!out_valid_reg || out_ready);
    assign q_head_len    = q_len_reg[q_fetch_reg];
    assign fetch_is_last = (fetch_word_reg == q_head_len - 14'd1);

    assign data_count_next    = data_count_reg + (accept ? 16'd4 : 16'd0) - (consume ? 16'd4 : 16'd0);
    assign pkt_count_next     = pkt_count_reg + 4'(push) - 4'(drain_last);
    assign fetch_pending_next = fetch_pending_reg + 4'(push) - 4'(fetch && fetch_is_last);

    for (genvar gi = 0; gi < PKT_QUEUE_DEPTH; gi++) begin : g_qsel
        assign q_sel[gi] = push && (q_wr_reg == QW'(gi));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PKT_QUEUE_DEPTH; i++) q_len_reg[i] <= '0;
        end else begin
            for (int i = 0; i < PKT_QUEUE_DEPTH; i++)
                if (q_sel[i]) q_len_reg[i] <= pkt_bytes_reg[15:2];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_reg] <= {in_be, in_data};
    end

    always_ff @(posedge clk) begin
        if (!reset_n)   rd_word_reg <= '0;
        else if (fetch) rd_word_reg <= mem[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            xfer_req_reg      <= 1'b0;
            xfer_active_reg   <= 1'b0;
            has_space_reg     <= 1'b0;
            err_reg           <= 1'b0;
            pkt_bytes_reg     <= '0;
            data_count_reg    <= '0;
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            q_wr_reg          <= '0;
            q_fetch_reg       <= '0;
            fetch_pending_reg <= '0;
            pkt_count_reg     <= '0;
            fetch_word_reg    <= '0;
            out_valid_reg     <= 1'b0;
            out_last_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_rx_avail && has_space_reg) begin
                        state_reg    <= REQ;
                        xfer_req_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (xfer_grant) begin
                        state_reg       <= ACTIVE;
                        xfer_req_reg    <= 1'b0;
                        xfer_active_reg <= 1'b1;
                        pkt_bytes_reg   <= '0;
                    end else if (!in_rx_avail) begin
                        state_reg    <= IDLE;
                        xfer_req_reg <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (accept) pkt_bytes_reg <= pkt_bytes_reg + 16'd4;
                    if (in_end || (accept && (pkt_bytes_reg + 16'd4 == MAX_BYTES))) begin
                        state_reg       <= CLOSE;
                        xfer_active_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (accept) wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (in_en && !accept) err_reg <= 1'b1;
            if (push) q_wr_reg <= q_wr_reg + 1'b1;

            data_count_reg    <= data_count_next;
            pkt_count_reg     <= pkt_count_next;
            fetch_pending_reg <= fetch_pending_next;
            has_space_reg     <= (data_count_next <= SPACE_LIMIT) && (pkt_count_next < QDEPTH);

            if (fetch) begin
                rd_ptr_reg    <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
                out_valid_reg <= 1'b1;
                out_last_reg  <= fetch_is_last;
                if (fetch_is_last) begin
                    fetch_word_reg <= '0;
                    q_fetch_reg    <= q_fetch_reg + 1'b1;
                end else begin
                    fetch_word_reg <= fetch_word_reg + 14'd1;
                end
            end else if (consume) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign xfer_req         = xfer_req_reg;
    assign xfer_active      = xfer_active_reg;
    assign has_packet_space = has_space_reg;
    assign out_data         = rd_word_reg[31:0];
    assign out_be           = rd_word_reg[35:32];
    assign out_valid        = out_valid_reg;
    assign out_last         = out_last_reg;
    assign out_packet_count = pkt_count_reg;
    assign err_overflow     = err_reg;
endmodule

// File: tb/tb_ft601_mcfifo_rd_buf.sv
// Directed bench: cycle table for handshake and a 3-word packet, then burst/fill/backpressure/reset sequences.
module tb_ft601_mcfifo_rd_buf;
    logic        clk = 1'b0;
    logic        reset_n, in_en, in_end, in_rx_avail, xfer_grant, out_ready;
    logic [31:0] in_data;
    logic [3:0]  in_be;
    logic        xfer_req, xfer_active, has_packet_space, out_valid, out_last, err_overflow;
    logic [31:0] out_data;
    logic [3:0]  out_be, out_packet_count;

    int errors = 0;
    int checks = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    ft601_mcfifo_rd_buf dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_be(in_be), .in_en(in_en),
        .in_end(in_end), .in_rx_avail(in_rx_avail), .xfer_req(xfer_req), .xfer_grant(xfer_grant),
        .xfer_active(xfer_active), .has_packet_space(has_packet_space), .out_data(out_data),
        .out_be(out_be), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .out_packet_count(out_packet_count), .err_overflow(err_overflow)
    );

    typedef struct {
        logic rst_n, rx, gr, en, ed;
        logic [31:0] data;
        logic req, act, hps, val, last;
        logic [31:0] edata;
        logic [3:0] cnt;
        logic err;
    } vec_t;

    function automatic logic [3:0] be_of(input logic [31:0] d);
        return d[7:4] ^ d[3:0] ^ d[31:28];
    endfunction

    function automatic vec_t mk(input logic rst_n, rx, gr, en, ed, input logic [31:0] data,
                                input logic req, act, hps, val, last, input logic [31:0] edata,
                                input logic [3:0] cnt, input logic err);
        vec_t v;
        v.rst_n = rst_n; v.rx = rx; v.gr = gr; v.en = en; v.ed = ed; v.data = data;
        v.req = req; v.act = act; v.hps = hps; v.val = val; v.last = last;
        v.edata = edata; v.cnt = cnt; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset_n = 1'b0; in_en = 0; in_end = 0; in_rx_avail = 0; xfer_grant = 0; out_ready = 0;
        in_data = '0; in_be = '0;
        tick(); tick();
        check("rst_valid", out_valid, 0);
        check("rst_count", out_packet_count, 0);
        check("rst_active", xfer_active, 0);
        reset_n = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic start_burst();
        in_rx_avail = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (xfer_req) break;
        end
        check("req_seen", xfer_req, 1);
        xfer_grant = 1'b1; in_rx_avail = 1'b0;
        tick();
        xfer_grant = 1'b0;
        check("burst_active", xfer_active, 1);
    endtask

    task automatic send_words(input int n, input logic [31:0] base, input bit end_last);
        logic last_b;
        for (int i = 0; i < n; i++) begin
            in_data = base + 32'(i);
            in_be = be_of(in_data);
            in_en = 1'b1;
            last_b = (i == n - 1);
            in_end = end_last && last_b;
            exp_q.push_back({last_b, in_be, in_data});
            tick();
        end
        in_en = 1'b0; in_end = 1'b0;
    endtask

    task automatic drain(input int n, input bit random_ready, input int budget);
        int got_n = 0;
        int cyc = 0;
        logic [36:0] e;
        while (got_n < n && cyc < budget) begin
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin
                got_n++;
                check("sb_has_word", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("word%0d", got_n), {out_last, out_be, out_data}, e);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_count", got_n, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[22];
        localparam logic [31:0] D1 = 32'hA5A5_0013, D2 = 32'h5A5A_0027, D3 = 32'hDEAD_BEEF;
        reset_n = 0; in_en = 0; in_end = 0; in_rx_avail = 0; xfer_grant = 0; out_ready = 0;
        in_data = '0; in_be = '0;

        //           rst rx gr en ed data   req act hps val last edata cnt err
        vt[0]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0);
        vt[1]  = mk(0, 1, 0, 1, 0, D1, 0, 0, 0, 0, 0, 0,  0, 0);
        vt[2]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 0);
        vt[3]  = mk(1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0,  0, 0);
        vt[4]  = mk(1, 1, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 0);
        vt[5]  = mk(1, 0, 0, 1, 0, D1, 0, 1, 1, 0, 0, 0,  0, 0);
        vt[6]  = mk(1, 0, 0, 1, 0, D2, 0, 1, 1, 0, 0, 0,  0, 0);
        vt[7]  = mk(1, 0, 0, 1, 1, D3, 0, 0, 1, 0, 0, 0,  0, 0);
        vt[8]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  1, 0);
        vt[9]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, D1, 1, 0);
        vt[10] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, D2, 1, 0);
        vt[11] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, D3, 1, 0);
        vt[12] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 0);
        vt[13] = mk(1, 0, 0, 1, 0, D1, 0, 0, 1, 0, 0, 0,  0, 1);
        vt[14] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 1);
        vt[15] = mk(1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0,  0, 1);
        vt[16] = mk(1, 0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 0,  0, 1);
        vt[17] = mk(1, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0,  0, 1);
        vt[18] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 1);
        vt[19] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 1);
        vt[20] = mk(1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0,  0, 1);
        vt[21] = mk(1, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0,  0, 1);

        for (int i = 0; i < 22; i++) begin
            reset_n = vt[i].rst_n; in_rx_avail = vt[i].rx; xfer_grant = vt[i].gr;
            in_en = vt[i].en; in_end = vt[i].ed; in_data = vt[i].data; in_be = be_of(vt[i].data);
            out_ready = 1'b1;
            tick();
            check($sformatf("v%0d_req", i), xfer_req, vt[i].req);
            check($sformatf("v%0d_active", i), xfer_active, vt[i].act);
            check($sformatf("v%0d_space", i), has_packet_space, vt[i].hps);
            check($sformatf("v%0d_valid", i), out_valid, vt[i].val);
            check($sformatf("v%0d_last", i), out_last, vt[i].last);
            check($sformatf("v%0d_count", i), out_packet_count, vt[i].cnt);
            check($sformatf("v%0d_err", i), err_overflow, vt[i].err);
            if (vt[i].val) begin
                check($sformatf("v%0d_data", i), out_data, vt[i].edata);
                check($sformatf("v%0d_be", i), out_be, be_of(vt[i].edata));
            end
        end

        // Max-size burst closes itself; one extra word in CLOSE is dropped and flagged.
        reset_dut();
        check("a_err_clear", err_overflow, 0);
        start_burst();
        send_words(256, 32'h0100_0000, 0);
        check("a_auto_close", xfer_active, 0);
        in_en = 1'b1; in_data = 32'hBAD0_BAD0; in_be = 4'hF;
        tick();
        in_en = 1'b0;
        check("a_err_close", err_overflow, 1);
        check("a_count", out_packet_count, 1);
        drain(256, 0, 600);
        tick();
        check("a_count_after", out_packet_count, 0);
        check("a_valid_after", out_valid, 0);

        // Fill the buffer with no draining, then empty it under random backpressure.
        reset_dut();
        for (int k = 0; k < 7; k++) begin
            start_burst();
            send_words(256, 32'(k + 2) << 24, 0);
            tick();
        end
        check("b_space_7168", has_packet_space, 1);
        check("b_count7", out_packet_count, 7);
        start_burst();
        send_words(256, 32'h0900_0000, 0);
        tick();
        check("b_space_full", has_packet_space, 0);
        check("b_count8", out_packet_count, 8);
        in_rx_avail = 1'b1;
        repeat (5) tick();
        check("b_no_req", xfer_req, 0);
        in_rx_avail = 1'b0;
        drain(2048, 1, 8000);
        tick();
        check("b_count_empty", out_packet_count, 0);
        check("b_space_back", has_packet_space, 1);

        // Back-to-back short packets (including a single word) drained concurrently.
        reset_dut();
        fork
            begin
                start_burst(); send_words(1, 32'h3000_0000, 1); tick();
                start_burst(); send_words(5, 32'h3100_0040, 1); tick();
                start_burst(); send_words(3, 32'h3200_0080, 1); tick();
                start_burst(); send_words(2, 32'h3300_00C0, 1); tick();
            end
            drain(11, 1, 3000);
        join
        tick();
        check("c_count_empty", out_packet_count, 0);
        check("c_err", err_overflow, 0);

        // Reset in the middle of a burst discards the partial packet.
        reset_dut();
        start_burst();
        send_words(4, 32'h4400_0000, 0);
        reset_dut();
        check("d_valid", out_valid, 0);
        check("d_count", out_packet_count, 0);
        start_burst();
        send_words(2, 32'h4500_0010, 1);
        drain(2, 0, 100);
        tick(); tick();
        check("d_valid_end", out_valid, 0);
        check("d_count_end", out_packet_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
